inst_fetch_buf: RTL and testbench

Fetch stage directly downstream of the program counter. Takes the current word-addressed pc, issues in-order requests to instruction memory, and holds up to DEPTH in-flight or returned instructions in a reservation queue. Presents {pc, instruction} pairs to decode with a valid/ready handshake. A redirect from branch/jump resolution flushes the queue and discards stale responses.

---
 rtl/inst_fetch_buf_if.sv | 29 ++
 rtl/inst_fetch_buf.sv | 151 +++++++++++++++
 tb/tb_inst_fetch_buf.sv | 304 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/inst_fetch_buf_if.sv
// Fetch-buffer bus bundle: program-counter input, instruction-memory request/response and
// decode-side handshake. 'master' is the fetch buffer, 'slave' is its environment.
interface inst_fetch_buf_if #(
    parameter int unsigned AW = 32
) ();
    logic [AW-1:0] pc;
    logic          pc_vld;
    logic          flush;
    logic          fetch_stall;
    logic          imem_req;
    logic [AW-1:0] imem_addr;
    logic          imem_gnt;
    logic          imem_rvld;
    logic [31:0]   imem_rdata;
    logic          if_vld;
    logic [31:0]   if_instr;
    logic [AW-1:0] if_pc;
    logic          if_rdy;

    modport master (
        input  pc, pc_vld, flush, imem_gnt, imem_rvld, imem_rdata, if_rdy,
        output fetch_stall, imem_req, imem_addr, if_vld, if_instr, if_pc
    );

    modport slave (
        output pc, pc_vld, flush, imem_gnt, imem_rvld, imem_rdata, if_rdy,
        input  fetch_stall, imem_req, imem_addr, if_vld, if_instr, if_pc
    );
endinterface

// File: rtl/inst_fetch_buf.sv
// In-order instruction fetch buffer with redirect flush and stale-response dropping.
// Define IFB_PERF_EN to add the stall/flush performance counter outputs.
module inst_fetch_buf #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = 32
) (
    input  logic             clk,
    input  logic             rst,
    inst_fetch_buf_if.master bus
`ifdef IFB_PERF_EN
    ,
    output logic [31:0]      perf_stall_cnt,
    output logic [31:0]      perf_flush_cnt
`endif
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    typedef logic [PW-1:0] ptr_t;
    typedef logic [CW-1:0] cnt_t;

    localparam cnt_t DepthC = cnt_t'(DEPTH);

    ptr_t wr_ptr_q, wr_ptr_d;
    ptr_t fill_ptr_q, fill_ptr_d;
    ptr_t rd_ptr_q, rd_ptr_d;
    cnt_t occ_q, occ_d;
    cnt_t outst_q, outst_d;
    cnt_t drop_cnt_q, drop_cnt_d;

    logic [AW-1:0]    pc_q    [DEPTH];
    logic [AW-1:0]    pc_d    [DEPTH];
    logic [31:0]      instr_q [DEPTH];
    logic [31:0]      instr_d [DEPTH];
    logic [DEPTH-1:0] filled_q, filled_d;

    logic imem_req;
    logic accept;
    logic fetch_stall;
    logic rsp_drop;
    logic rsp_fill;
    logic if_vld;
    logic pop;

    // Issue check uses pre-pop occupancy; discarded requests still hold capacity.
    assign imem_req    = rst & bus.pc_vld & ~bus.flush & ((occ_q + drop_cnt_q) < DepthC);
    assign accept      = imem_req & bus.imem_gnt;
    assign fetch_stall = rst & bus.pc_vld & ~accept;
    assign rsp_drop    = bus.imem_rvld & (drop_cnt_q != '0);
    assign rsp_fill    = bus.imem_rvld & (drop_cnt_q == '0) & (outst_q != '0);
    assign if_vld      = filled_q[rd_ptr_q] & ~bus.flush;
    assign pop         = if_vld & bus.if_rdy;

    assign bus.imem_req    = imem_req;
    assign bus.imem_addr   = bus.pc;
    assign bus.fetch_stall = fetch_stall;
    assign bus.if_vld      = if_vld;
    assign bus.if_instr    = instr_q[rd_ptr_q];
    assign bus.if_pc       = pc_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        fill_ptr_d = fill_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        occ_d      = occ_q;
        outst_d    = outst_q;
        drop_cnt_d = drop_cnt_q;
        pc_d       = pc_q;
        instr_d    = instr_q;
        filled_d   = filled_q;

        if (bus.flush) begin
            wr_ptr_d   = '0;
            fill_ptr_d = '0;
            rd_ptr_d   = '0;
            occ_d      = '0;
            outst_d    = '0;
            filled_d   = '0;
            // Live requests become drops; a response this cycle retires one of either kind.
            drop_cnt_d = drop_cnt_q + outst_q - cnt_t'(rsp_drop | rsp_fill);
        end else begin
            if (accept) begin
                pc_d[wr_ptr_q]     = bus.pc;
                filled_d[wr_ptr_q] = 1'b0;
                wr_ptr_d           = wr_ptr_q + ptr_t'(1);
            end
            if (rsp_drop) begin
                drop_cnt_d = drop_cnt_q - cnt_t'(1);
            end
            if (rsp_fill) begin
                instr_d[fill_ptr_q]  = bus.imem_rdata;
                filled_d[fill_ptr_q] = 1'b1;
                fill_ptr_d           = fill_ptr_q + ptr_t'(1);
            end
            if (pop) begin
                filled_d[rd_ptr_q] = 1'b0;
                rd_ptr_d           = rd_ptr_q + ptr_t'(1);
            end
            occ_d   = occ_q + cnt_t'(accept) - cnt_t'(pop);
            outst_d = outst_q + cnt_t'(accept) - cnt_t'(rsp_fill);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q   <= '0;
            fill_ptr_q <= '0;
            rd_ptr_q   <= '0;
            occ_q      <= '0;
            outst_q    <= '0;
            drop_cnt_q <= '0;
            pc_q       <= '{default: '0};
            instr_q    <= '{default: '0};
            filled_q   <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            fill_ptr_q <= fill_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            occ_q      <= occ_d;
            outst_q    <= outst_d;
            drop_cnt_q <= drop_cnt_d;
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            filled_q   <= filled_d;
        end
    end

`ifdef IFB_PERF_EN
    logic [31:0] perf_stall_q, perf_stall_d;
    logic [31:0] perf_flush_q, perf_flush_d;

    always_comb begin
        perf_stall_d = perf_stall_q + 32'(fetch_stall);
        perf_flush_d = perf_flush_q + 32'(bus.flush);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_stall_q <= '0;
            perf_flush_q <= '0;
        end else begin
            perf_stall_q <= perf_stall_d;
            perf_flush_q <= perf_flush_d;
        end
    end

    assign perf_stall_cnt = perf_stall_q;
    assign perf_flush_cnt = perf_flush_q;
`endif

endmodule

// File: tb/tb_inst_fetch_buf.sv
// Scoreboard bench for inst_fetch_buf: randomized memory/decode/redirect behaviour with
// directed streaming, backpressure, flush and async-reset episodes.
module tb_inst_fetch_buf;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned AW    = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    inst_fetch_buf_if #(.AW(AW)) bus ();

`ifdef IFB_PERF_EN
    logic [31:0] perf_stall_cnt;
    logic [31:0] perf_flush_cnt;
`endif

    inst_fetch_buf #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk            (clk),
        .rst            (rst),
        .bus            (bus)
`ifdef IFB_PERF_EN
        ,
        .perf_stall_cnt (perf_stall_cnt),
        .perf_flush_cnt (perf_flush_cnt)
`endif
    );

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    typedef struct {
        logic [31:0] addr;
        int          ready;
        bit          dead;
    } mreq_t;

    int checks   = 0;
    int failures = 0;

    exp_t  sbq[$];   // fetches accepted and not yet delivered to decode
    mreq_t memq[$];  // requests the memory still owes a response for
    int    dead_cnt;
    int    cyc;
    int    last_ready;

    int k_vld, k_gnt, k_rdy, k_flush, k_lat_min, k_lat_max;
    bit force_flush;
    logic [31:0] next_pc;
    logic [31:0] flush_tgt;
    int model_stalls, model_flushes;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        return 32'h1000_0000 + addr;
    endfunction

    task automatic drive();
        if (memq.size() > 0 && memq[0].ready <= cyc) begin
            bus.imem_rvld  = 1'b1;
            bus.imem_rdata = mem_word(memq[0].addr);
        end else begin
            bus.imem_rvld  = 1'b0;
            bus.imem_rdata = $urandom;
        end
        bus.imem_gnt = ($urandom_range(99) < k_gnt);
        bus.if_rdy   = ($urandom_range(99) < k_rdy);
        bus.pc_vld   = ($urandom_range(99) < k_vld);
        if (force_flush) begin
            bus.flush = 1'b1;
        end else begin
            bus.flush = ($urandom_range(99) < k_flush);
            flush_tgt = $urandom_range(32'hffff);
        end
        bus.pc = next_pc;
    endtask

    // Reference model: capacity = undelivered accepted fetches + responses still owed for
    // requests abandoned by a redirect.
    task automatic sample();
        logic exp_req;
        mreq_t m;
        int lat;
        exp_req = bus.pc_vld && !bus.flush && (sbq.size() + dead_cnt < DEPTH);
        check("imem_req", bus.imem_req, exp_req);
        check("fetch_stall", bus.fetch_stall, bus.pc_vld && !(exp_req && bus.imem_gnt));
        if (exp_req) check("imem_addr", bus.imem_addr, next_pc);
        if (bus.pc_vld && !(exp_req && bus.imem_gnt)) model_stalls++;
        if (bus.flush) model_flushes++;

        if (bus.imem_rvld) begin
            m = memq.pop_front();
            if (m.dead) dead_cnt--;
        end
        if (bus.flush) begin
            sbq.delete();
            foreach (memq[i]) begin
                if (!memq[i].dead) begin
                    memq[i].dead = 1'b1;
                    dead_cnt++;
                end
            end
            next_pc = flush_tgt;
        end
        if (bus.imem_req && bus.imem_gnt) begin
            lat = $urandom_range(k_lat_max, k_lat_min);
            m.addr  = bus.imem_addr;
            m.ready = (cyc + lat > last_ready) ? cyc + lat : last_ready + 1;
            m.dead  = 1'b0;
            last_ready = m.ready;
            memq.push_back(m);
        end
        if (exp_req && bus.imem_gnt) begin
            sbq.push_back({next_pc, mem_word(next_pc)});
            next_pc = ($urandom_range(9) == 0) ? $urandom : next_pc + 32'd1;
        end
        cyc++;
    endtask

    task automatic run(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            drive();
            @(negedge clk);
            sample();
        end
    endtask

    task automatic knobs(input int vld, input int gnt, input int rdy, input int fl,
                         input int lmin, input int lmax);
        k_vld = vld; k_gnt = gnt; k_rdy = rdy; k_flush = fl;
        k_lat_min = lmin; k_lat_max = lmax;
    endtask

    task automatic drain();
        knobs(0, 100, 100, 0, 1, 1);
        run(30);
        check("drain_left", sbq.size(), 0);
        check("drain_if_vld", bus.if_vld, 1'b0);
    endtask

    task automatic reset_clear();
        sbq.delete();
        memq.delete();
        dead_cnt      = 0;
        last_ready    = cyc;
        model_stalls  = 0;
        model_flushes = 0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_if_vld"}, bus.if_vld, 1'b0);
        check({tag, "_imem_req"}, bus.imem_req, 1'b0);
        check({tag, "_fetch_stall"}, bus.fetch_stall, 1'b0);
        check({tag, "_if_pc"}, bus.if_pc, 32'h0);
        check({tag, "_if_instr"}, bus.if_instr, 32'h0);
    endtask

    task automatic perf_check(input string tag);
`ifdef IFB_PERF_EN
        check({tag, "_perf_stall"}, perf_stall_cnt, model_stalls);
        check({tag, "_perf_flush"}, perf_flush_cnt, model_flushes);
`else
        if (tag.len() < 0) $display("%s", tag);
`endif
    endtask

    initial begin : monitor
        exp_t e;
        logic hold;
        logic [31:0] hpc, hins;
        hold = 1'b0;
        hpc  = '0;
        hins = '0;
        forever begin
            @(negedge clk);
            #2;
            if (!rst) begin
                hold = 1'b0;
            end else begin
                if (bus.flush) begin
                    check("flush_if_vld", bus.if_vld, 1'b0);
                end else if (hold) begin
                    check("hold_vld", bus.if_vld, 1'b1);
                    check("hold_pc", bus.if_pc, hpc);
                    check("hold_instr", bus.if_instr, hins);
                end
                if (bus.if_vld && bus.if_rdy) begin
                    if (sbq.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_delivery: got pc %h required none", bus.if_pc);
                    end else begin
                        e = sbq.pop_front();
                        check("if_pc", bus.if_pc, e.pc);
                        check("if_instr", bus.if_instr, e.instr);
                    end
                end
                hold = bus.if_vld && !bus.if_rdy && !bus.flush;
                hpc  = bus.if_pc;
                hins = bus.if_instr;
            end
        end
    end

    initial begin : stim
        bus.pc = '0; bus.pc_vld = 1'b0; bus.flush = 1'b0; bus.imem_gnt = 1'b0;
        bus.imem_rvld = 1'b0; bus.imem_rdata = '0; bus.if_rdy = 1'b0;
        force_flush = 1'b0; flush_tgt = '0; next_pc = '0; cyc = 0;
        reset_clear();

        #1 rst = 1'b0;
        #1 bus.pc_vld = 1'b1;
        #1 check_reset_outputs("por");
        perf_check("por");
        @(negedge clk);
        #1 bus.pc_vld = 1'b0;
        rst = 1'b1;

        // Streaming, 1-cycle memory.
        next_pc = 32'h0;
        knobs(100, 100, 100, 0, 1, 1);
        run(30);
        drain();

        // Backpressure, then a single decode pulse.
        next_pc = 32'h0;
        knobs(100, 100, 0, 0, 1, 1);
        run(8);
        k_rdy = 100;
        run(1);
        k_rdy = 0;
        run(3);
        drain();

        // Flush with three requests in flight, redirect to 0x40.
        next_pc = 32'h8;
        knobs(100, 100, 100, 0, 3, 3);
        run(3);
        force_flush = 1'b1;
        flush_tgt   = 32'h40;
        run(1);
        force_flush = 1'b0;
        run(12);
        drain();

        // Flush coincident with a response and a would-be pop.
        next_pc = 32'h4;
        knobs(100, 100, 100, 0, 2, 2);
        run(3);
        force_flush = 1'b1;
        flush_tgt   = 32'h100;
        run(1);
        force_flush = 1'b0;
        run(15);
        drain();

        knobs(80, 70, 70, 4, 1, 4);
        run(1500);
        perf_check("mid");

        // Async reset between edges with entries queued.
        knobs(100, 100, 0, 0, 1, 1);
        run(3);
        @(posedge clk);
        #3;
        bus.pc_vld = 1'b1;
        bus.imem_rvld = 1'b0;
        bus.flush = 1'b0;
        bus.if_rdy = 1'b1;
        rst = 1'b0;
        #1 check_reset_outputs("async");
        reset_clear();
        @(negedge clk);
        @(negedge clk);
        #1;
        bus.pc_vld = 1'b0;
        bus.if_rdy = 1'b0;
        rst = 1'b1;
        perf_check("post_rst");
        next_pc = 32'h200;
        knobs(100, 100, 100, 0, 1, 1);
        run(20);

        knobs(75, 60, 60, 5, 1, 3);
        run(800);
        drain();
        perf_check("final");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
